// File: rtl/turf_udp_hsk_mux.sv
// Purpose : route UDP housekeeping packets to one of NCHAN channels by destination
//           port, remember each channel's last sender, and count drops/truncations.
// Latency : payload is a zero-latency combinational pass-through; header takes 1 cycle.
// Backpres: upstream data ready follows the selected channel's ready; unrouted or
//           truncated remainders are drained at full rate; headers stall outside IDLE.
// Ports   : s_udphdr_*  header stream {src_ip, src_port, dst_port}
//           s_udpdata_* payload stream in; m_udpdata_* per-channel payload out (slice k)
//           ret_*_o     per-channel last-sender address; *_count_o saturating counters
module turf_udp_hsk_mux #(
   parameter int          NCHAN      = 2,
   parameter logic [15:0] BASE_PORT  = 16'h5368,
   parameter int          MAX_BEATS  = 64,
   parameter logic [31:0] DEFAULT_IP = {8'd10, "DA", 8'd1}
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [63:0]           s_udphdr_tdata,
   input  logic                  s_udphdr_tvalid,
   output logic                  s_udphdr_tready,
   input  logic [63:0]           s_udpdata_tdata,
   input  logic [7:0]            s_udpdata_tkeep,
   input  logic                  s_udpdata_tlast,
   input  logic                  s_udpdata_tvalid,
   output logic                  s_udpdata_tready,
   output logic [64*NCHAN-1:0]   m_udpdata_tdata,
   output logic [8*NCHAN-1:0]    m_udpdata_tkeep,
   output logic [NCHAN-1:0]      m_udpdata_tlast,
   output logic [NCHAN-1:0]      m_udpdata_tvalid,
   input  logic [NCHAN-1:0]      m_udpdata_tready,
   output logic [32*NCHAN-1:0]   ret_ip_o,
   output logic [16*NCHAN-1:0]   ret_port_o,
   output logic [NCHAN-1:0]      ret_valid_o,
   output logic [15:0]           drop_count_o,
   output logic [15:0]           trunc_count_o
);

   localparam int          SELW      = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [SELW-1:0]     sel_q, sel_d;
   logic [15:0]         beat_q, beat_d;
   logic [15:0]         drop_q, drop_d;
   logic [15:0]         trunc_q, trunc_d;
   logic [32*NCHAN-1:0] ret_ip_q, ret_ip_d;
   logic [16*NCHAN-1:0] ret_port_q, ret_port_d;
   logic [NCHAN-1:0]    ret_valid_q, ret_valid_d;

   logic [15:0] idx;
   logic        routed;
   logic        hdr_hs;
   logic        data_hs;
   logic        at_limit;
   logic        ret_ld;
   logic        drop_inc;
   logic        trunc_inc;

   // Channel index; a destination below BASE_PORT wraps to a large value and is dropped.
   assign idx      = s_udphdr_tdata[15:0] - BASE_PORT;
   assign routed   = (idx < 16'(NCHAN));

   // Reset forces IDLE asynchronously, so the header ready must be masked explicitly.
   assign s_udphdr_tready = (state_q == IDLE) && !areset;
   assign hdr_hs          = s_udphdr_tvalid && s_udphdr_tready;
   assign data_hs         = s_udpdata_tvalid && s_udpdata_tready;

   // The beat currently offered is number beat_q+1; this flags the last allowed beat.
   assign at_limit = (beat_q == LAST_BEAT);

   // Data and keep are broadcast; only the selected channel's tvalid qualifies them.
   assign m_udpdata_tdata = {NCHAN{s_udpdata_tdata}};
   assign m_udpdata_tkeep = {NCHAN{s_udpdata_tkeep}};

   always_comb begin
      state_d          = state_q;
      sel_d            = sel_q;
      beat_d           = beat_q;
      ret_ld           = 1'b0;
      drop_inc         = 1'b0;
      trunc_inc        = 1'b0;
      s_udpdata_tready = 1'b0;
      m_udpdata_tvalid = '0;
      m_udpdata_tlast  = '0;

      case (state_q)
         IDLE: begin
            if (hdr_hs) begin
               if (routed) begin
                  sel_d   = idx[SELW-1:0];
                  beat_d  = 16'd0;
                  ret_ld  = 1'b1;
                  state_d = FWD;
               end else begin
                  drop_inc = 1'b1;
                  state_d  = DRAIN;
               end
            end
         end

         FWD: begin
            s_udpdata_tready          = m_udpdata_tready[sel_q];
            m_udpdata_tvalid[sel_q]   = s_udpdata_tvalid;
            // A packet that reaches the beat limit is closed off downstream here.
            m_udpdata_tlast[sel_q]    = s_udpdata_tlast || at_limit;
            if (data_hs) begin
               beat_d = beat_q + 16'd1;
               if (s_udpdata_tlast) begin
                  state_d = IDLE;
               end else if (at_limit) begin
                  trunc_inc = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end

         DRAIN: begin
            s_udpdata_tready = 1'b1;
            if (data_hs && s_udpdata_tlast) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      drop_d      = (drop_inc  && (drop_q  != 16'hFFFF)) ? drop_q  + 16'd1 : drop_q;
      trunc_d     = (trunc_inc && (trunc_q != 16'hFFFF)) ? trunc_q + 16'd1 : trunc_q;
      ret_ip_d    = ret_ip_q;
      ret_port_d  = ret_port_q;
      ret_valid_d = ret_valid_q;
      for (int k = 0; k < NCHAN; k++) begin
         if (ret_ld && (idx == 16'(k))) begin
            ret_ip_d[k*32 +: 32]   = s_udphdr_tdata[63:32];
            ret_port_d[k*16 +: 16] = s_udphdr_tdata[31:16];
            ret_valid_d[k]         = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         beat_q      <= 16'd0;
         drop_q      <= 16'd0;
         trunc_q     <= 16'd0;
         ret_valid_q <= '0;
         for (int k = 0; k < NCHAN; k++) begin
            ret_ip_q[k*32 +: 32]   <= DEFAULT_IP;
            ret_port_q[k*16 +: 16] <= BASE_PORT + 16'(k);
         end
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         beat_q      <= beat_d;
         drop_q      <= drop_d;
         trunc_q     <= trunc_d;
         ret_ip_q    <= ret_ip_d;
         ret_port_q  <= ret_port_d;
         ret_valid_q <= ret_valid_d;
      end
   end

   assign ret_ip_o      = ret_ip_q;
   assign ret_port_o    = ret_port_q;
   assign ret_valid_o   = ret_valid_q;
   assign drop_count_o  = drop_q;
   assign trunc_count_o = trunc_q;

endmodule
